// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, fed by core stores.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0100,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable_i,
    input  logic        read_enable_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        tx_o,
    output logic        busy_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_ADV = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    localparam logic PAR_ADV = 1'b0;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    state_e           state_q, state_d;
    logic [15:0]      baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [15:0]      div_q, div_d;
    logic [15:0]      baud_div_q, baud_div_d;
    logic             ovf_q, ovf_d;
    logic             tx_q, tx_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic sel_tx, sel_st, sel_bd;
    logic full, empty, push_req, push, pop, load, bit_done;
    logic [7:0] head;
    logic unused_bits;

    assign sel_tx = (address_i[31:2] == BASE_W);
    assign sel_st = (address_i[31:2] == BASE_W + 30'd1);
    assign sel_bd = (address_i[31:2] == BASE_W + 30'd2);
    assign unused_bits = ^{address_i[1:0], write_data_i[31:16]};

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign head     = mem_q[rptr_q];
    assign push_req = write_enable_i & sel_tx;
    // A push into a full FIFO still fits when the shifter pops on the same edge.
    assign push     = push_req & (~full | pop);
    assign bit_done = (baud_cnt_q == div_q - 16'd1);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        div_d      = div_q;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        load       = 1'b0;
        case (state_q)
            S_IDLE: load = ~empty;
            S_START: begin
                if (bit_done) begin
                    state_d    = S_DATA;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_d    = S_STOP;
                    baud_cnt_d = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (!empty) load = 1'b1;
                    else        state_d = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The divisor is captured per frame so BAUD_DIV writes only affect later frames.
        if (load) begin
            state_d    = S_START;
            shift_d    = head;
            div_d      = baud_div_q;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
            par_d      = ^head;
`endif
        end
        pop = load;

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wptr_d     = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d     = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        count_d    = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        baud_div_d = baud_div_q;
        if (write_enable_i && sel_bd)
            baud_div_d = (write_data_i[15:0] == 16'd0) ? 16'd1 : write_data_i[15:0];
        ovf_d = ovf_q;
        if (write_enable_i && sel_st && write_data_i[3]) ovf_d = 1'b0;
        if (push_req && full && !pop)                    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            baud_div_q <= DEFAULT_DIV;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            baud_div_q <= baud_div_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= write_data_i[7:0];
        shift_q <= shift_d;
        div_q   <= div_d;
`ifdef UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

    always_comb begin
        read_data_o = '0;
        if (read_enable_i) begin
            if (sel_st)
                read_data_o = {23'd0, PAR_ADV, 4'(count_q), ovf_q,
                               (state_q != S_IDLE), empty, full};
            else if (sel_bd)
                read_data_o = {16'd0, baud_div_q};
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != S_IDLE) | ~empty;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vectors, directed frame sequences
// and randomized traffic against a frame-schedule reference model.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h1001_0100;
    localparam int          DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          FB    = 11;
    localparam logic [31:0] PARB  = 32'h100;
`else
    localparam int          FB    = 10;
    localparam logic [31:0] PARB  = 32'h0;
`endif
    localparam logic [31:0] TXD = 32'h0, STA = 32'h4, BDV = 32'h8;

    logic        clk = 1'b0;
    logic        reset, we, re;
    logic [31:0] addr, wdata, rdata;
    logic        tx, busy;
    int          checks = 0;
    int          errors = 0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd16)) dut (
        .clk(clk), .reset(reset), .write_enable_i(we), .read_enable_i(re),
        .address_i(addr), .write_data_i(wdata), .read_data_o(rdata),
        .tx_o(tx), .busy_o(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] off;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; we = 1'b0; re = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = BASE + off; wdata = d;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        @(negedge clk);
        re = 1'b1; addr = BASE + off;
        #1 d = rdata;
        re = 1'b0;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (FB == 11 && i == 9) return ^b;
        return 1'b1;
    endfunction

    // Samples tx one clock at a time, starting with the edge after the call.
    task automatic expect_frame(input logic [7:0] b, input int div, inout int bad);
        for (int k = 0; k < FB * div; k++) begin
            @(posedge clk);
            #1 if (tx !== frame_bit(b, k / div)) bad++;
        end
    endtask

    task automatic rand_run(input int run);
        logic        exp_tx  [1024];
        bit          push_at [1024];
        logic [7:0]  val_at  [1024];
        logic [7:0]  q[$];
        logic [7:0]  b;
        logic [31:0] r;
        int          d, n, t, nxt, total, bad, gmax;
        bit          exp_ovf;
        for (int i = 0; i < 1024; i++) begin
            exp_tx[i] = 1'b1; push_at[i] = 1'b0; val_at[i] = 8'h00;
        end
        d    = $urandom_range(1, 3);
        n    = $urandom_range(6, 12);
        gmax = (run % 2 == 1) ? 4 : 25;
        t    = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) begin
            push_at[t] = 1'b1;
            val_at[t]  = 8'($urandom);
            t += $urandom_range(1, gmax);
        end
        total = t + (n + 1) * FB * d + 8;

        // Frame scheduler: a frame starts at the first edge with queued data once the line is free.
        nxt = 0; exp_ovf = 1'b0;
        for (int e = 0; e < total; e++) begin
            if (q.size() > 0 && e >= nxt) begin
                b = q.pop_front();
                for (int k = 0; k < FB * d; k++)
                    if (e + k < 1024) exp_tx[e + k] = frame_bit(b, k / d);
                nxt = e + FB * d;
            end
            if (push_at[e]) begin
                if (q.size() < DEPTH) q.push_back(val_at[e]);
                else exp_ovf = 1'b1;
            end
        end

        do_reset();
        wr(BDV, 32'(d));
        bad = 0;
        for (int e = 0; e <= total; e++) begin
            @(negedge clk);
            if (e > 0 && tx !== exp_tx[e - 1]) bad++;
            we    = (e < total) && push_at[e];
            addr  = BASE + TXD;
            wdata = {24'($urandom), val_at[e]};
        end
        we = 1'b0;
        check($sformatf("rand%0d_wave_d%0d", run, d), 32'(bad), 32'd0);
        rd(STA, r);
        check($sformatf("rand%0d_status", run), r, PARB | 32'h2 | (exp_ovf ? 32'h8 : 32'h0));
    endtask

    initial begin
        logic [31:0] r;
        int          bad;
        vec_t        tv [18];

        tv[0]  = '{1'b0, 1'b1, STA,           32'h0,         32'h2 | PARB};
        tv[1]  = '{1'b0, 1'b1, BDV,           32'h0,         32'd16};
        tv[2]  = '{1'b1, 1'b0, BDV,           32'd7,         32'h0};
        tv[3]  = '{1'b0, 1'b1, BDV,           32'h0,         32'd7};
        tv[4]  = '{1'b0, 1'b1, 32'hB,         32'h0,         32'd7};
        tv[5]  = '{1'b1, 1'b0, BDV,           32'h0,         32'h0};
        tv[6]  = '{1'b0, 1'b1, BDV,           32'h0,         32'd1};
        tv[7]  = '{1'b1, 1'b1, 32'hC,         32'h33,        32'h0};
        tv[8]  = '{1'b0, 1'b1, BDV,           32'h0,         32'd1};
        tv[9]  = '{1'b1, 1'b0, 32'hA,         32'hABCD_2345, 32'h0};
        tv[10] = '{1'b0, 1'b1, BDV,           32'h0,         32'h2345};
        tv[11] = '{1'b0, 1'b1, TXD,           32'h0,         32'h0};
        tv[12] = '{1'b1, 1'b0, STA,           32'h8,         32'h0};
        tv[13] = '{1'b0, 1'b1, STA,           32'h0,         32'h2 | PARB};
        tv[14] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'h0};
        tv[15] = '{1'b1, 1'b0, BDV,           32'd16,        32'h0};
        tv[16] = '{1'b0, 1'b0, BDV,           32'h0,         32'h0};
        tv[17] = '{1'b0, 1'b1, 32'h7,         32'h0,         32'h2 | PARB};

        reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        do_reset();

        // Reset state and idle line
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rd(STA, r); check("rst_status", r, 32'h2 | PARB);
        rd(BDV, r); check("rst_baud", r, 32'd16);
        bad = 0;
        repeat (200) begin
            @(posedge clk);
            #1 if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_200", 32'(bad), 32'd0);

        // Register access vectors
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            we = tv[i].we; re = tv[i].re; addr = BASE + tv[i].off; wdata = tv[i].wd;
            #1 check($sformatf("vec%0d", i), rdata, tv[i].exp);
            @(posedge clk);
            #1 begin we = 1'b0; re = 1'b0; end
        end

        // Single byte 0x55 at divisor 4
        wr(BDV, 32'd4);
        wr(TXD, 32'hFFFF_FF55);
        check("sb_tx_push_edge", 32'(tx), 32'd1);
        check("sb_busy", 32'(busy), 32'd1);
        rd(STA, r); check("sb_status_queued", r, 32'h10 | PARB);
        bad = 0;
        expect_frame(8'h55, 4, bad);
        check("sb_frame", 32'(bad), 32'd0);
        @(posedge clk);
        #1 check("sb_busy_done", 32'(busy), 32'd0);
        rd(STA, r); check("sb_status_done", r, 32'h2 | PARB);

        // Back-to-back frames with the FIFO filling to its depth
        wr(BDV, 32'd2);
        wr(TXD, 32'hA1);
        bad = 0;
        fork
            begin
                wr(TXD, 32'hB2); wr(TXD, 32'hC3); wr(TXD, 32'hD4); wr(TXD, 32'hE5);
                rd(STA, r); check("b2b_peak_status", r, 32'h45 | PARB);
            end
            begin
                expect_frame(8'hA1, 2, bad); expect_frame(8'hB2, 2, bad);
                expect_frame(8'hC3, 2, bad); expect_frame(8'hD4, 2, bad);
                expect_frame(8'hE5, 2, bad);
            end
        join
        check("b2b_frames", 32'(bad), 32'd0);
        @(posedge clk);
        #1 check("b2b_busy_done", 32'(busy), 32'd0);
        rd(STA, r); check("b2b_status_done", r, 32'h2 | PARB);

        // Overflow with a stalled shifter, then write-1-to-clear
        wr(BDV, 32'hFFFF);
        for (int i = 0; i < 6; i++) wr(TXD, 32'(i + 1));
        rd(STA, r); check("ovf_set", r, 32'h4D | PARB);
        check("ovf_tx_start", 32'(tx), 32'd0);
        wr(STA, 32'h8);
        rd(STA, r); check("ovf_clear", r, 32'h45 | PARB);
        do_reset();

        // Divisor change mid-frame applies only to the next frame
        wr(BDV, 32'd3);
        wr(TXD, 32'h00);
        bad = 0;
        fork
            begin
                repeat (6) @(posedge clk);
                wr(BDV, 32'd5);
                wr(TXD, 32'h3C);
            end
            begin
                expect_frame(8'h00, 3, bad);
                expect_frame(8'h3C, 5, bad);
            end
        join
        check("div_change_frames", 32'(bad), 32'd0);
        @(posedge clk);
        #1 check("div_change_idle_tx", 32'(tx), 32'd1);
        rd(BDV, r); check("div_readback", r, 32'd5);
        wr(BDV, 32'd0);
        rd(BDV, r); check("div_zero_is_one", r, 32'd1);

        // Reset in the middle of data bit 3
        wr(BDV, 32'd4);
        wr(TXD, 32'h00);
        wr(TXD, 32'hFF);
        repeat (17) @(posedge clk);
        #1 check("rmid_in_bit3", 32'(tx), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 begin
            check("rmid_tx_high", 32'(tx), 32'd1);
            check("rmid_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        rd(STA, r); check("rmid_status", r, 32'h2 | PARB);
        rd(BDV, r); check("rmid_baud", r, 32'd16);
        wr(TXD, 32'hA5);
        bad = 0;
        expect_frame(8'hA5, 16, bad);
        check("rmid_after_frame", 32'(bad), 32'd0);

        // Randomized traffic against the frame-schedule model
        for (int run = 0; run < 4; run++) rand_run(run);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
